perceptron_vec_tx: RTL
======================

// Module: perceptron_vec_tx
// PURPOSE
//  Transmit side of the perceptron val/rdy stream. Accepts one packed feature
//  vector plus label per handshake and serializes it, one element per beat,
//  into the perceptron control/datapath input port (val_o/rdy_i -> val_i/rdy_o).
//  Sits between the sample store/test harness and the perceptron core.
// PARAMETERS
//  DIM    4   number of feature elements per vector (>=1)
//  W      8   element width, signed fixed point
//  FRAC   4   fractional bits of element format (bias constant = 1<<FRAC)
//  CNT_W  16  width of transmitted-vector counter
// PORTS
//  clk        in   1        clock
//  reset      in   1        synchronous, active-high reset
//  in_val     in   1        upstream vector valid
//  in_rdy     out  1        block can capture a vector this cycle
//  in_vec     in   DIM*W    packed vector; element k at [k*W +: W]
//  in_label   in   1        target class of vector
//  out_val    out  1        element beat valid to perceptron
//  out_rdy    in   1        perceptron ready for beat
//  out_data   out  W        current element
//  out_last   out  1        marks final beat of vector
//  out_label  out  1        label of vector in flight, stable over all beats
//  busy       out  1        vector held (state SEND)
//  vec_count  out  CNT_W    number of vectors fully transmitted
// BEHAVIOUR
//  Reset: reset, synchronous, active-high; clock clk. Outputs after reset:
//   in_rdy=1, out_val=0, out_data=0, out_last=0, out_label=0, busy=0,
//   vec_count=0. Reset mid-vector abandons it; no further beats issued.
//  Beats per vector: N = DIM (N = DIM+1 with bias, see CONFIGURATION).
//  FSM: IDLE / SEND. idx counter 0..N-1, width clog2(N+1).
//   IDLE: in_rdy=1, out_val=0. in_val&in_rdy -> capture in_vec/in_label into
//    holding register, idx=0, -> SEND. First beat valid the next cycle.
//   SEND: out_val=1, out_data=element[idx], out_last=(idx==N-1).
//    out_val&out_rdy & !out_last -> idx+1.
//    out_val&out_rdy &  out_last -> vec_count+1 (wraps 2^CNT_W-1 -> 0);
//     if in_val in same cycle: capture new vector, idx=0, stay SEND (zero
//     bubble); else -> IDLE.
//  in_rdy = IDLE | (SEND & out_last & out_rdy) — combinational from out_rdy.
//  Stall: while out_val & !out_rdy, out_data/out_last/out_label held stable;
//   out_val never deasserts before transfer.
//  in_vec/in_label ignored when in_rdy=0; no write-through of new data into a
//   vector in flight.
//  Element order: element 0 first, element DIM-1 last (before bias).
//  Throughput: one beat per cycle when out_rdy=1; N cycles per vector steady.
//  busy = (state==SEND).
// CONFIGURATION
//  PERC_BIAS_EN defined: N=DIM+1; extra final beat out_data = 1<<FRAC
//   (fixed-point 1.0), out_last on that beat only.
//  PERC_BIAS_EN undefined: N=DIM; out_last on element DIM-1; no bias beat.
// TESTING
//  1 reset: hold reset 2 cycles mid-SEND -> next cycle out_val=0, in_rdy=1,
//    vec_count=0.
//  2 DIM=4,W=8, in_vec=32'h04_03_02_01, label=1, out_rdy=1 -> beats 01,02,03,04
//    on consecutive cycles, out_last on 04, out_label=1, vec_count=1.
//  3 backpressure: out_rdy=0 for 3 cycles on beat 2 -> out_data=02 held stable,
//    out_val=1 throughout; resumes 03 after out_rdy=1.
//  4 back-to-back: in_val high continuously with vectors A,B -> B captured on A's
//    last beat, B element 0 next cycle, no idle cycle; vec_count=2.
//  5 PERC_BIAS_EN, FRAC=4 -> 5 beats, final beat 8'h10 with out_last; without
//    macro, out_last on element 3 and no 5th beat.
//  6 counter wrap: CNT_W=2, send 5 vectors -> vec_count 1,2,3,0,1.

Source files
------------

// File: rtl/perceptron_vec_tx.sv
// Serializes one packed feature vector plus label per handshake into element beats.
// Optional PERC_BIAS_EN appends a fixed-point 1.0 bias beat after the last element.
module perceptron_vec_tx #(
   parameter int DIM   = 4,
   parameter int W     = 8,
   parameter int FRAC  = 4,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_val,
   output logic               in_rdy,
   input  logic [DIM*W-1:0]   in_vec,
   input  logic               in_label,
   output logic               out_val,
   input  logic               out_rdy,
   output logic [W-1:0]       out_data,
   output logic               out_last,
   output logic               out_label,
   output logic               busy,
   output logic [CNT_W-1:0]   vec_count
);

`ifdef PERC_BIAS_EN
   localparam int N       = DIM + 1;
   localparam bit BIAS_EN = 1'b1;
`else
   localparam int N       = DIM;
   localparam bit BIAS_EN = 1'b0;
`endif
   localparam int                IDX_W    = $clog2(N + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0]  BIAS_IDX = IDX_W'(DIM);
   localparam logic [W-1:0]      BIAS_VAL = W'(1) << FRAC;

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state, state_nxt;
   logic [DIM*W-1:0]   vec_q;
   logic               label_q;
   logic [IDX_W-1:0]   idx;
   logic               accept;
   logic               beat;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      in_rdy    = 1'b0;
      out_val   = 1'b0;
      out_last  = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_rdy = 1'b1;
            if (in_val) state_nxt = SEND;
         end
         SEND: begin
            out_val  = 1'b1;
            busy     = 1'b1;
            out_last = (idx == LAST_IDX);
            // Ready on the final beat lets the next vector follow with no bubble.
            in_rdy   = out_last & out_rdy;
            if (out_last && out_rdy && !in_val) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept    = in_val & in_rdy;
   assign beat      = out_val & out_rdy;
   assign out_label = label_q;

   always_comb begin
      out_data = '0;
      if (state == SEND) begin
         for (int k = 0; k < DIM; k++) begin
            if (idx == IDX_W'(k)) out_data = vec_q[k*W +: W];
         end
         if (BIAS_EN && idx == BIAS_IDX) out_data = BIAS_VAL;
      end
   end

   // NOTE: the holding register is reset too, so out_label and out_data read 0 after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         vec_q     <= '0;
         label_q   <= 1'b0;
         idx       <= '0;
         vec_count <= '0;
      end else begin
         if (accept) begin
            vec_q   <= in_vec;
            label_q <= in_label;
            idx     <= '0;
         end else if (beat && !out_last) begin
            idx <= idx + IDX_W'(1);
         end
         if (beat && out_last) vec_count <= vec_count + CNT_W'(1);
      end
   end

endmodule
